// File: rtl/sram_bist_pkg.sv
// -----------------------------------------------------------------------------
// sram_bist_pkg
// Shared definitions for the March C- BIST initiator of the 64x128 SRAM:
//   - bist_state_e   : controller states (IDLE, RUN, CHECK, DONE)
//   - NUM_ELEMENTS   : number of march elements (6)
//   - elem_desc_t    : per-element descriptor (direction, read/write ops, data)
//   - MARCH_C_MINUS  : constant table of the six March C- elements
//   - elem_desc()    : safe table lookup (out-of-range index -> no-op element)
//   - elem_is_down() : direction of an element, used for next start address
// -----------------------------------------------------------------------------
package sram_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } bist_state_e;

  localparam int NUM_ELEMENTS = 6;

  // One march element. A two-op element always performs its read first.
  typedef struct packed {
    logic dir_down;   // 1: walk 63 -> 0, 0: walk 0 -> 63
    logic has_read;
    logic read_val;   // expected data bit, replicated over the word
    logic has_write;
    logic write_val;  // written data bit, replicated over the word
  } elem_desc_t;

  // Field order: dir_down, has_read, read_val, has_write, write_val
  localparam elem_desc_t MARCH_C_MINUS [NUM_ELEMENTS] = '{
    '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0},  // 0 up   (w0)
    '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1},  // 1 up   (r0, w1)
    '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0},  // 2 up   (r1, w0)
    '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1},  // 3 down (r0, w1)
    '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0},  // 4 down (r1, w0)
    '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0}   // 5 up   (r0)
  };

  // Index is 3 bits wide; codes 6 and 7 map to an element that does nothing.
  function automatic elem_desc_t elem_desc(input logic [2:0] idx);
    elem_desc_t d;
    case (idx)
      3'd0:    d = MARCH_C_MINUS[0];
      3'd1:    d = MARCH_C_MINUS[1];
      3'd2:    d = MARCH_C_MINUS[2];
      3'd3:    d = MARCH_C_MINUS[3];
      3'd4:    d = MARCH_C_MINUS[4];
      3'd5:    d = MARCH_C_MINUS[5];
      default: d = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    endcase
    return d;
  endfunction

  function automatic logic elem_is_down(input logic [2:0] idx);
    elem_desc_t d;
    d = elem_desc(idx);
    return d.dir_down;
  endfunction

endpackage

// File: rtl/sram_bist_64x128_cmp.sv
// -----------------------------------------------------------------------------
// sram_bist_cmp
// Registered compare stage of the BIST. A read issued in cycle N is captured
// ({expected, address, element, valid}) at the end of cycle N; in cycle N+1
// the SRAM output Q is compared with the captured expectation and the result
// is registered at the end of that cycle. Only the first miscompare of a run
// is latched into the fail address/element.
//
// Optional feature (macro SRAM_BIST_DIAG_EN): saturating miscompare counter
// and the XOR syndrome of the first miscompare.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   i_clear          start of a new run: clears all results
//   i_rd_valid       a BIST read is issued this cycle
//   i_rd_exp         expected data bit of that read (replicated)
//   i_rd_addr        address of that read
//   i_rd_elem        march element of that read
//   i_q              SRAM read data (valid the cycle after the read)
//   o_fail           sticky miscompare flag
//   o_fail_addr      address of the first miscompare
//   o_fail_elem      element of the first miscompare
//   o_fail_count     (DIAG) saturating miscompare count
//   o_fail_bits      (DIAG) expected XOR Q at the first miscompare
// -----------------------------------------------------------------------------
module sram_bist_cmp
  import sram_bist_pkg::*;
#(
  parameter int ADDR_BITS = 6,
  parameter int WIDTH     = 128
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_clear,
  input  logic                 i_rd_valid,
  input  logic                 i_rd_exp,
  input  logic [ADDR_BITS-1:0] i_rd_addr,
  input  logic [2:0]           i_rd_elem,
  input  logic [WIDTH-1:0]     i_q,
`ifdef SRAM_BIST_DIAG_EN
  output logic [9:0]           o_fail_count,
  output logic [WIDTH-1:0]     o_fail_bits,
`endif
  output logic                 o_fail,
  output logic [ADDR_BITS-1:0] o_fail_addr,
  output logic [2:0]           o_fail_elem
);

  logic                 r_pend_valid;
  logic [WIDTH-1:0]     r_pend_exp;
  logic [ADDR_BITS-1:0] r_pend_addr;
  logic [2:0]           r_pend_elem;

  logic                 r_fail;
  logic [ADDR_BITS-1:0] r_fail_addr;
  logic [2:0]           r_fail_elem;

  logic [WIDTH-1:0]     w_diff;
  logic                 w_mismatch;

  assign w_diff     = i_q ^ r_pend_exp;
  assign w_mismatch = r_pend_valid & (|w_diff);

  // Capture the pending read so it lines up with Q in the following cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_valid <= 1'b0;
      r_pend_exp   <= {WIDTH{1'b0}};
      r_pend_addr  <= {ADDR_BITS{1'b0}};
      r_pend_elem  <= 3'd0;
    end else if (i_clear) begin
      r_pend_valid <= 1'b0;
      r_pend_exp   <= {WIDTH{1'b0}};
      r_pend_addr  <= {ADDR_BITS{1'b0}};
      r_pend_elem  <= 3'd0;
    end else begin
      r_pend_valid <= i_rd_valid;
      r_pend_exp   <= {WIDTH{i_rd_exp}};
      r_pend_addr  <= i_rd_addr;
      r_pend_elem  <= i_rd_elem;
    end
  end

  // Sticky fail flag; address/element frozen at the first miscompare
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fail      <= 1'b0;
      r_fail_addr <= {ADDR_BITS{1'b0}};
      r_fail_elem <= 3'd0;
    end else if (i_clear) begin
      r_fail      <= 1'b0;
      r_fail_addr <= {ADDR_BITS{1'b0}};
      r_fail_elem <= 3'd0;
    end else if (w_mismatch && !r_fail) begin
      r_fail      <= 1'b1;
      r_fail_addr <= r_pend_addr;
      r_fail_elem <= r_pend_elem;
    end else begin
      r_fail      <= r_fail;
      r_fail_addr <= r_fail_addr;
      r_fail_elem <= r_fail_elem;
    end
  end

  assign o_fail      = r_fail;
  assign o_fail_addr = r_fail_addr;
  assign o_fail_elem = r_fail_elem;

`ifdef SRAM_BIST_DIAG_EN
  logic [9:0]       r_fail_count;
  logic [WIDTH-1:0] r_fail_bits;

  // Saturating miscompare count and first-failure syndrome
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fail_count <= 10'd0;
      r_fail_bits  <= {WIDTH{1'b0}};
    end else if (i_clear) begin
      r_fail_count <= 10'd0;
      r_fail_bits  <= {WIDTH{1'b0}};
    end else begin
      if (w_mismatch && (r_fail_count != 10'd1023)) begin
        r_fail_count <= r_fail_count + 10'd1;
      end else begin
        r_fail_count <= r_fail_count;
      end
      if (w_mismatch && !r_fail) begin
        r_fail_bits <= w_diff;
      end else begin
        r_fail_bits <= r_fail_bits;
      end
    end
  end

  assign o_fail_count = r_fail_count;
  assign o_fail_bits  = r_fail_bits;
`endif

endmodule

// File: rtl/sram_bist_64x128.sv
// -----------------------------------------------------------------------------
// sram_bist_64x128
// March C- BIST initiator between the functional requester and a 64x128
// single-port byte-enable SRAM. In IDLE/DONE the SRAM pins are a straight
// passthrough of the Func* inputs; in RUN/CHECK the BIST owns the pins,
// issues one SRAM operation per cycle (640 ops) and then spends one CHECK
// cycle comparing the final read.
//
// Optional feature (macro SRAM_BIST_DIAG_EN): FailCount / FailBits outputs.
//
// Ports:
//   CLK, RSTB                 clock, asynchronous active-low reset
//   Start                     start pulse (honoured in IDLE/DONE only)
//   Busy                      BIST owns the SRAM
//   Done                      run complete, held until the next Start
//   Fail                      sticky miscompare flag
//   FailAddr, FailElement     first failing address / march element
//   FailCount, FailBits       (DIAG) miscompare count / first syndrome
//   FuncCEB, FuncWEB, FuncA,
//   FuncD, FuncBWEB           functional SRAM request (active-low enables)
//   FuncQ                     read data to the functional side (= Q)
//   CEB, WEB, A, D, BWEB      SRAM pins
//   Q                         SRAM read data, valid the cycle after a read
// -----------------------------------------------------------------------------
module sram_bist_64x128
  import sram_bist_pkg::*;
#(
  parameter int ADDR_BITS = 6,
  parameter int WIDTH     = 128
) (
  input  logic                 CLK,
  input  logic                 RSTB,
  input  logic                 Start,
  output logic                 Busy,
  output logic                 Done,
  output logic                 Fail,
  output logic [ADDR_BITS-1:0] FailAddr,
  output logic [2:0]           FailElement,
`ifdef SRAM_BIST_DIAG_EN
  output logic [9:0]           FailCount,
  output logic [WIDTH-1:0]     FailBits,
`endif
  input  logic                 FuncCEB,
  input  logic                 FuncWEB,
  input  logic [ADDR_BITS-1:0] FuncA,
  input  logic [WIDTH-1:0]     FuncD,
  input  logic [WIDTH-1:0]     FuncBWEB,
  output logic [WIDTH-1:0]     FuncQ,
  output logic                 CEB,
  output logic                 WEB,
  output logic [ADDR_BITS-1:0] A,
  output logic [WIDTH-1:0]     D,
  output logic [WIDTH-1:0]     BWEB,
  input  logic [WIDTH-1:0]     Q
);

  localparam logic [2:0] LAST_ELEM = 3'(NUM_ELEMENTS - 1);

  bist_state_e          r_state;
  logic [2:0]           r_elem;
  logic [ADDR_BITS-1:0] r_addr;
  logic                 r_phase;   // 0: read slot, 1: write slot of a two-op element
  logic                 r_busy;
  logic                 r_done;

  bist_state_e          w_state_nxt;
  logic [2:0]           w_elem_nxt;
  logic [ADDR_BITS-1:0] w_addr_nxt;
  logic                 w_phase_nxt;
  logic                 w_start_run;

  elem_desc_t           w_desc;
  logic                 w_run;
  logic                 w_own;
  logic                 w_bist_rd;
  logic                 w_bist_wr;
  logic                 w_op_last;
  logic                 w_addr_last;

  assign w_desc      = elem_desc(r_elem);
  assign w_run       = (r_state == ST_RUN);
  assign w_own       = (r_state == ST_RUN) || (r_state == ST_CHECK);
  assign w_bist_rd   = w_run & w_desc.has_read  & (~w_desc.has_write | ~r_phase);
  assign w_bist_wr   = w_run & w_desc.has_write & (~w_desc.has_read  |  r_phase);
  // A single-op element finishes its address in one cycle.
  assign w_op_last   = ~(w_desc.has_read & w_desc.has_write) | r_phase;
  assign w_addr_last = w_desc.dir_down ? (r_addr == {ADDR_BITS{1'b0}})
                                       : (r_addr == {ADDR_BITS{1'b1}});

  // State register, march counters and registered status flags
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      r_state <= ST_IDLE;
      r_elem  <= 3'd0;
      r_addr  <= {ADDR_BITS{1'b0}};
      r_phase <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_elem  <= w_elem_nxt;
      r_addr  <= w_addr_nxt;
      r_phase <= w_phase_nxt;
      r_busy  <= (w_state_nxt == ST_RUN) || (w_state_nxt == ST_CHECK);
      r_done  <= (w_state_nxt == ST_DONE);
    end
  end

  // Next-state and march sequencing
  always_comb begin
    w_state_nxt = r_state;
    w_elem_nxt  = r_elem;
    w_addr_nxt  = r_addr;
    w_phase_nxt = r_phase;
    w_start_run = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (Start) begin
          w_state_nxt = ST_RUN;
          w_elem_nxt  = 3'd0;
          w_addr_nxt  = {ADDR_BITS{1'b0}};
          w_phase_nxt = 1'b0;
          w_start_run = 1'b1;
        end else begin
          w_state_nxt = r_state;
        end
      end
      ST_RUN: begin
        if (w_op_last) begin
          w_phase_nxt = 1'b0;
          if (w_addr_last) begin
            if (r_elem == LAST_ELEM) begin
              w_state_nxt = ST_CHECK;
            end else begin
              // Wrap onto the start address of the following element.
              w_elem_nxt = r_elem + 3'd1;
              w_addr_nxt = elem_is_down(r_elem + 3'd1) ? {ADDR_BITS{1'b1}}
                                                       : {ADDR_BITS{1'b0}};
            end
          end else if (w_desc.dir_down) begin
            w_addr_nxt = r_addr - {{(ADDR_BITS-1){1'b0}}, 1'b1};
          end else begin
            w_addr_nxt = r_addr + {{(ADDR_BITS-1){1'b0}}, 1'b1};
          end
        end else begin
          w_phase_nxt = 1'b1;
        end
      end
      ST_CHECK: begin
        w_state_nxt = ST_DONE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // SRAM pin ownership: functional passthrough unless the BIST is running
  always_comb begin
    CEB  = FuncCEB;
    WEB  = FuncWEB;
    A    = FuncA;
    D    = FuncD;
    BWEB = FuncBWEB;
    if (w_own) begin
      // CHECK issues no operation; RUN issues one every cycle.
      CEB  = ~w_run;
      WEB  = ~w_bist_wr;
      A    = r_addr;
      D    = {WIDTH{w_desc.write_val}};
      BWEB = w_bist_wr ? {WIDTH{1'b0}} : {WIDTH{1'b1}};
    end else begin
      CEB  = FuncCEB;
    end
  end

  assign FuncQ = Q;
  assign Busy  = r_busy;
  assign Done  = r_done;

  sram_bist_cmp #(
    .ADDR_BITS (ADDR_BITS),
    .WIDTH     (WIDTH)
  ) u_cmp (
    .clk          (CLK),
    .rst_n        (RSTB),
    .i_clear      (w_start_run),
    .i_rd_valid   (w_bist_rd),
    .i_rd_exp     (w_desc.read_val),
    .i_rd_addr    (r_addr),
    .i_rd_elem    (r_elem),
    .i_q          (Q),
`ifdef SRAM_BIST_DIAG_EN
    .o_fail_count (FailCount),
    .o_fail_bits  (FailBits),
`endif
    .o_fail       (Fail),
    .o_fail_addr  (FailAddr),
    .o_fail_elem  (FailElement)
  );

endmodule

// File: tb/tb_sram_bist_64x128.sv
// -----------------------------------------------------------------------------
// tb_sram_bist_64x128
// Directed bench for sram_bist_64x128 with a behavioural 64x128 SRAM that can
// carry one stuck-at fault (applied on read at a chosen address).
// -----------------------------------------------------------------------------
module tb_sram_bist_64x128;

  localparam int AW = 6;
  localparam int W  = 128;

  logic          CLK = 1'b0;
  logic          RSTB;
  logic          Start;
  logic          Busy, Done, Fail;
  logic [AW-1:0] FailAddr;
  logic [2:0]    FailElement;
`ifdef SRAM_BIST_DIAG_EN
  logic [9:0]    FailCount;
  logic [W-1:0]  FailBits;
`endif
  logic          FuncCEB, FuncWEB;
  logic [AW-1:0] FuncA;
  logic [W-1:0]  FuncD, FuncBWEB, FuncQ;
  logic          CEB, WEB;
  logic [AW-1:0] A;
  logic [W-1:0]  D, BWEB, Q;

  // behavioural SRAM with one optional faulty cell
  logic [W-1:0]  mem [64];
  logic          fault_en;
  logic [AW-1:0] fault_addr;
  logic [W-1:0]  fault_sa0, fault_sa1;

  int n_vec;
  int n_miss;

  typedef struct packed {
    logic          wr;
    logic          val;
    logic [AW-1:0] a;
  } op_t;
  op_t exp_ops[$];

  sram_bist_64x128 #(.ADDR_BITS(AW), .WIDTH(W)) dut (
    .CLK         (CLK),
    .RSTB        (RSTB),
    .Start       (Start),
    .Busy        (Busy),
    .Done        (Done),
    .Fail        (Fail),
    .FailAddr    (FailAddr),
    .FailElement (FailElement),
`ifdef SRAM_BIST_DIAG_EN
    .FailCount   (FailCount),
    .FailBits    (FailBits),
`endif
    .FuncCEB     (FuncCEB),
    .FuncWEB     (FuncWEB),
    .FuncA       (FuncA),
    .FuncD       (FuncD),
    .FuncBWEB    (FuncBWEB),
    .FuncQ       (FuncQ),
    .CEB         (CEB),
    .WEB         (WEB),
    .A           (A),
    .D           (D),
    .BWEB        (BWEB),
    .Q           (Q)
  );

  always #5 CLK = ~CLK;

  // SRAM model: bit-masked write, registered read with stuck-at overlay
  always @(posedge CLK) begin
    if (CEB == 1'b0) begin
      if (WEB == 1'b0) begin
        mem[A] <= (mem[A] & BWEB) | (D & ~BWEB);
      end else if (fault_en && (A == fault_addr)) begin
        Q <= (mem[A] & ~fault_sa0) | fault_sa1;
      end else begin
        Q <= mem[A];
      end
    end
  end

  task automatic check_vec(input string tag, input logic [W-1:0] obs,
                           input logic [W-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_op(input logic wr, input logic val, input int a);
    op_t op;
    op.wr  = wr;
    op.val = val;
    op.a   = AW'(a);
    exp_ops.push_back(op);
  endtask

  // March C- op list built from the element table, one entry per RUN cycle
  task automatic build_ops();
    for (int e = 0; e < 6; e++) begin
      for (int i = 0; i < 64; i++) begin
        int a;
        a = (e == 3 || e == 4) ? (63 - i) : i;
        case (e)
          0: push_op(1'b1, 1'b0, a);
          1: begin push_op(1'b0, 1'b0, a); push_op(1'b1, 1'b1, a); end
          2: begin push_op(1'b0, 1'b1, a); push_op(1'b1, 1'b0, a); end
          3: begin push_op(1'b0, 1'b0, a); push_op(1'b1, 1'b1, a); end
          4: begin push_op(1'b0, 1'b1, a); push_op(1'b1, 1'b0, a); end
          default: push_op(1'b0, 1'b0, a);
        endcase
      end
    end
  endtask

  task automatic func_idle();
    FuncCEB  = 1'b1;
    FuncWEB  = 1'b1;
    FuncA    = '0;
    FuncD    = '0;
    FuncBWEB = '1;
  endtask

  // Start a run, check pins every cycle against the op list, time Busy
  task automatic run_bist(input int abort_at, input bit drive_func);
    int  cycles;
    int  seq_err;
    bit  overlap;
    op_t op;
    cycles  = 0;
    seq_err = 0;
    overlap = 1'b0;
    @(negedge CLK);
    Start = 1'b1;
    @(negedge CLK);
    Start = 1'b0;
    check_vec("start_clears_done", Done, 0);
    check_vec("start_clears_fail", Fail, 0);
    check_vec("start_clears_addr", FailAddr, 0);
    check_vec("start_clears_elem", FailElement, 0);
    while (Busy && cycles < 2000) begin
      cycles++;
      if (cycles == 1 && drive_func) begin
        FuncCEB = 1'b0; FuncWEB = 1'b0; FuncA = 6'd3;
        FuncD = {16{8'hA5}}; FuncBWEB = '0;
        #1;
      end
      if (cycles == 100) Start = 1'b1;
      if (cycles == 101) Start = 1'b0;
      if (Done) overlap = 1'b1;
      if (cycles <= 640) begin
        op = exp_ops[cycles-1];
        if (CEB !== 1'b0 || WEB !== ~op.wr || A !== op.a) seq_err++;
        if (op.wr && (D !== {W{op.val}} || BWEB !== {W{1'b0}})) seq_err++;
      end else if (CEB !== 1'b1) begin
        seq_err++;
      end
      if (cycles == abort_at) break;
      @(negedge CLK);
    end
    if (drive_func) func_idle();
    if (abort_at == 0) begin
      check_vec("busy_cycles", cycles, 641);
      check_vec("done_after_run", Done, 1);
      check_vec("busy_done_overlap", overlap, 0);
      check_vec("op_sequence", seq_err, 0);
    end else begin
      check_vec("abort_seq", seq_err, 0);
    end
  endtask

  initial begin
    logic [W-1:0] exp_bits;
    int nonzero;
    n_vec  = 0;
    n_miss = 0;
    build_ops();
    RSTB = 1'b0;
    Start = 1'b0;
    func_idle();
    fault_en = 1'b0; fault_addr = '0; fault_sa0 = '0; fault_sa1 = '0;
    repeat (3) @(negedge CLK);
    check_vec("rst_busy", Busy, 0);
    check_vec("rst_done", Done, 0);
    check_vec("rst_fail", Fail, 0);
    check_vec("rst_failaddr", FailAddr, 0);
    check_vec("rst_failelem", FailElement, 0);
    RSTB = 1'b1;
    @(negedge CLK);

    // idle passthrough: write 0xA5.. to addr 3, read it back
    FuncCEB = 1'b0; FuncWEB = 1'b0; FuncA = 6'd3;
    FuncD = {16{8'hA5}}; FuncBWEB = '0;
    #1;
    check_vec("pt_ceb", CEB, 0);
    check_vec("pt_web", WEB, 0);
    check_vec("pt_a", A, 3);
    check_vec("pt_d", D, {16{8'hA5}});
    check_vec("pt_bweb", BWEB, 0);
    @(negedge CLK);
    FuncWEB = 1'b1;
    @(negedge CLK);
    check_vec("pt_funcq", FuncQ, {16{8'hA5}});
    func_idle();

    // fault-free run with functional writes held active while Busy
    run_bist(0, 1'b1);
    check_vec("clean_fail", Fail, 0);
    nonzero = 0;
    for (int i = 0; i < 64; i++) if (mem[i] !== '0) nonzero++;
    check_vec("clean_mem_zero", nonzero, 0);
`ifdef SRAM_BIST_DIAG_EN
    check_vec("clean_count", FailCount, 0);
`endif

    // stuck-at-0, addr 5 bit 17
    fault_en = 1'b1; fault_addr = 6'd5; fault_sa0 = '0; fault_sa0[17] = 1'b1; fault_sa1 = '0;
    run_bist(0, 1'b0);
    check_vec("sa0_fail", Fail, 1);
    check_vec("sa0_addr", FailAddr, 5);
    check_vec("sa0_elem", FailElement, 2);
`ifdef SRAM_BIST_DIAG_EN
    exp_bits = '0; exp_bits[17] = 1'b1;
    check_vec("sa0_count", FailCount, 2);
    check_vec("sa0_bits", FailBits, exp_bits);
`endif

    // stuck-at-1, addr 63 bit 0
    fault_addr = 6'd63; fault_sa0 = '0; fault_sa1 = '0; fault_sa1[0] = 1'b1;
    run_bist(0, 1'b0);
    check_vec("sa1_fail", Fail, 1);
    check_vec("sa1_addr", FailAddr, 63);
    check_vec("sa1_elem", FailElement, 1);
`ifdef SRAM_BIST_DIAG_EN
    exp_bits = '0; exp_bits[0] = 1'b1;
    check_vec("sa1_count", FailCount, 3);
    check_vec("sa1_bits", FailBits, exp_bits);
`endif

    // fault removed, restart from DONE: results cleared, run passes
    fault_en = 1'b0;
    run_bist(0, 1'b0);
    check_vec("rerun_fail", Fail, 0);
    check_vec("rerun_addr", FailAddr, 0);
    check_vec("rerun_elem", FailElement, 0);

    // reset at RUN cycle 300 (fault present, Fail already set)
    fault_en = 1'b1;
    run_bist(300, 1'b0);
    check_vec("pre_abort_fail", Fail, 1);
    RSTB = 1'b0;
    #1;
    check_vec("abort_busy", Busy, 0);
    check_vec("abort_done", Done, 0);
    check_vec("abort_fail", Fail, 0);
    check_vec("abort_failaddr", FailAddr, 0);
    @(negedge CLK);
    RSTB = 1'b1;
    fault_en = 1'b0;
    run_bist(0, 1'b0);
    check_vec("post_abort_fail", Fail, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
